// File: rtl/ball_split_scheduler_if.sv
// Hit-request handshake from the collision logic and the shared ball
// configuration bus, bundled so both sides see one consistent view.
interface ball_split_scheduler_if #(
   parameter int NUM_SLOTS = 8
);
   localparam int SW = $clog2(NUM_SLOTS);

   logic                 hitValid;
   logic                 hitReady;
   logic [SW-1:0]        hitSlot;
   logic [10:0]          hitX;
   logic [10:0]          hitY;

   logic                 cfgLoad;
   logic [SW-1:0]        cfgSlot;
   logic [10:0]          cfgX;
   logic [10:0]          cfgY;
   logic signed [15:0]   cfgXspeed;
   logic signed [15:0]   cfgYspeed;
   logic [1:0]           cfgSize;

   modport master (
      output hitValid, hitSlot, hitX, hitY,
      input  hitReady, cfgLoad, cfgSlot, cfgX, cfgY, cfgXspeed, cfgYspeed, cfgSize
   );

   modport slave (
      input  hitValid, hitSlot, hitX, hitY,
      output hitReady, cfgLoad, cfgSlot, cfgX, cfgY, cfgXspeed, cfgYspeed, cfgSize
   );
endinterface

// File: rtl/ball_split_scheduler.sv
// Ball pool scheduler: spawns the level-start ball, serialises pop/split
// events and reloads ball instances over one shared configuration bus.
module ball_split_scheduler #(
   parameter int NUM_SLOTS    = 8,
   parameter int MAX_SIZE     = 3,
   parameter int SPLIT_XSPEED = 64,
   parameter int SPLIT_YSPEED = -256,
   parameter int LEVEL_X      = 100,
   parameter int LEVEL_Y      = 100,
   parameter int LEVEL_XSPEED = 64,
   parameter int LEVEL_YSPEED = 0
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   levelStart,
   ball_split_scheduler_if.slave  bus,
   output logic [NUM_SLOTS-1:0]   slotActive,
   output logic                   allCleared,
   output logic                   overflow
);
   localparam int SW = $clog2(NUM_SLOTS);

   localparam logic signed [15:0] XS_POS  = 16'(SPLIT_XSPEED);
   localparam logic signed [15:0] XS_NEG  = 16'(-SPLIT_XSPEED);
   localparam logic signed [15:0] YS      = 16'(SPLIT_YSPEED);
   localparam logic signed [15:0] LVL_XS  = 16'(LEVEL_XSPEED);
   localparam logic signed [15:0] LVL_YS  = 16'(LEVEL_YSPEED);

   typedef enum logic [2:0] {IDLE, LVL_INIT, SPLIT_L, SPLIT_R, CHECK} state_t;

   state_t                         state_reg, state_next;
   logic [NUM_SLOTS-1:0]           active_reg, active_next;
   logic [NUM_SLOTS-1:0][1:0]      size_reg, size_next;
   logic                           pending_reg, pending_next;
   logic                           overflow_reg, overflow_next;

   // The cfg registers double as the latch for the split in progress.
   logic                           cfg_load_reg, cfg_load_next;
   logic [SW-1:0]                  cfg_slot_reg, cfg_slot_next;
   logic [10:0]                    cfg_x_reg, cfg_x_next;
   logic [10:0]                    cfg_y_reg, cfg_y_next;
   logic signed [15:0]             cfg_xs_reg, cfg_xs_next;
   logic signed [15:0]             cfg_ys_reg, cfg_ys_next;
   logic [1:0]                     cfg_size_reg, cfg_size_next;

   logic                           hit_ready;
   logic [NUM_SLOTS-1:0]           occupied;
   logic                           free_found;
   logic [SW-1:0]                  free_idx;

   assign hit_ready = (state_reg == IDLE) && !levelStart && !pending_reg;

   // Right child search treats the left child's slot as already re-activated.
   assign occupied = active_reg | (NUM_SLOTS'(1) << cfg_slot_reg);

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!occupied[i]) begin
            free_found = 1'b1;
            free_idx   = SW'(i);
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      active_next   = active_reg;
      size_next     = size_reg;
      pending_next  = pending_reg;
      overflow_next = overflow_reg;
      cfg_load_next = 1'b0;
      cfg_slot_next = cfg_slot_reg;
      cfg_x_next    = cfg_x_reg;
      cfg_y_next    = cfg_y_reg;
      cfg_xs_next   = cfg_xs_reg;
      cfg_ys_next   = cfg_ys_reg;
      cfg_size_next = cfg_size_reg;

      case (state_reg)
         IDLE: begin
            if (levelStart || pending_reg) begin
               state_next    = LVL_INIT;
               cfg_load_next = 1'b1;
               cfg_slot_next = '0;
               cfg_x_next    = 11'(LEVEL_X);
               cfg_y_next    = 11'(LEVEL_Y);
               cfg_xs_next   = LVL_XS;
               cfg_ys_next   = LVL_YS;
               cfg_size_next = 2'(MAX_SIZE);
            end else if (bus.hitValid && active_reg[bus.hitSlot]) begin
               active_next[bus.hitSlot] = 1'b0;
               if (size_reg[bus.hitSlot] == 2'd0) begin
                  state_next = CHECK;
               end else begin
                  state_next    = SPLIT_L;
                  cfg_load_next = 1'b1;
                  cfg_slot_next = bus.hitSlot;
                  cfg_x_next    = bus.hitX;
                  cfg_y_next    = bus.hitY;
                  cfg_xs_next   = XS_NEG;
                  cfg_ys_next   = YS;
                  cfg_size_next = size_reg[bus.hitSlot] - 2'd1;
               end
            end
         end
         LVL_INIT: begin
            active_next    = NUM_SLOTS'(1);
            size_next      = '0;
            size_next[0]   = 2'(MAX_SIZE);
            overflow_next  = 1'b0;
            pending_next   = 1'b0;
            state_next     = IDLE;
         end
         SPLIT_L: begin
            active_next[cfg_slot_reg] = 1'b1;
            size_next[cfg_slot_reg]   = cfg_size_reg;
            if (free_found) begin
               cfg_load_next = 1'b1;
               cfg_slot_next = free_idx;
               cfg_xs_next   = XS_POS;
            end
            state_next = SPLIT_R;
         end
         SPLIT_R: begin
            if (cfg_load_reg) begin
               active_next[cfg_slot_reg] = 1'b1;
               size_next[cfg_slot_reg]   = cfg_size_reg;
            end else begin
               overflow_next = 1'b1;
            end
            state_next = CHECK;
         end
         CHECK:   state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // A level start arriving mid-sequence waits for the next IDLE cycle.
      if (state_reg != IDLE && levelStart) begin
         pending_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg    <= IDLE;
         active_reg   <= '0;
         size_reg     <= '0;
         pending_reg  <= 1'b0;
         overflow_reg <= 1'b0;
         cfg_load_reg <= 1'b0;
         cfg_slot_reg <= '0;
         cfg_x_reg    <= '0;
         cfg_y_reg    <= '0;
         cfg_xs_reg   <= '0;
         cfg_ys_reg   <= '0;
         cfg_size_reg <= '0;
      end else begin
         state_reg    <= state_next;
         active_reg   <= active_next;
         size_reg     <= size_next;
         pending_reg  <= pending_next;
         overflow_reg <= overflow_next;
         cfg_load_reg <= cfg_load_next;
         cfg_slot_reg <= cfg_slot_next;
         cfg_x_reg    <= cfg_x_next;
         cfg_y_reg    <= cfg_y_next;
         cfg_xs_reg   <= cfg_xs_next;
         cfg_ys_reg   <= cfg_ys_next;
         cfg_size_reg <= cfg_size_next;
      end
   end

   assign bus.hitReady  = hit_ready;
   assign bus.cfgLoad   = cfg_load_reg;
   assign bus.cfgSlot   = cfg_slot_reg;
   assign bus.cfgX      = cfg_x_reg;
   assign bus.cfgY      = cfg_y_reg;
   assign bus.cfgXspeed = cfg_xs_reg;
   assign bus.cfgYspeed = cfg_ys_reg;
   assign bus.cfgSize   = cfg_size_reg;
   assign slotActive    = active_reg;
   assign allCleared    = (state_reg == CHECK) && (active_reg == '0);
   assign overflow      = overflow_reg;
endmodule

// File: tb/tb_ball_split_scheduler.sv
// Directed bench: an 8-slot pool for level start, splits, pending level
// start and reset, plus a 4-slot pool to reach overflow and level clear.
module tb_ball_split_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetN;
   logic        sel;
   logic        hv;
   logic [2:0]  hs;
   logic [10:0] hx, hy;
   logic        ls;

   ball_split_scheduler_if #(.NUM_SLOTS(8)) bus8();
   ball_split_scheduler_if #(.NUM_SLOTS(4)) bus4();

   logic [7:0] act8;
   logic [3:0] act4;
   logic       clr8, clr4, ovf8, ovf4;

   assign bus8.hitValid = hv & ~sel;
   assign bus8.hitSlot  = hs;
   assign bus8.hitX     = hx;
   assign bus8.hitY     = hy;
   assign bus4.hitValid = hv & sel;
   assign bus4.hitSlot  = hs[1:0];
   assign bus4.hitX     = hx;
   assign bus4.hitY     = hy;

   ball_split_scheduler #(.NUM_SLOTS(8)) dut8 (
      .clk(clk), .resetN(resetN), .levelStart(ls & ~sel), .bus(bus8.slave),
      .slotActive(act8), .allCleared(clr8), .overflow(ovf8)
   );

   ball_split_scheduler #(.NUM_SLOTS(4)) dut4 (
      .clk(clk), .resetN(resetN), .levelStart(ls & sel), .bus(bus4.slave),
      .slotActive(act4), .allCleared(clr4), .overflow(ovf4)
   );

   logic        o_ready, o_load, o_clr, o_ovf;
   logic [2:0]  o_slot;
   logic [10:0] o_x, o_y;
   logic [15:0] o_xs, o_ys;
   logic [1:0]  o_size;
   logic [7:0]  o_act;

   assign o_ready = sel ? bus4.hitReady : bus8.hitReady;
   assign o_load  = sel ? bus4.cfgLoad  : bus8.cfgLoad;
   assign o_slot  = sel ? {1'b0, bus4.cfgSlot} : bus8.cfgSlot;
   assign o_x     = sel ? bus4.cfgX : bus8.cfgX;
   assign o_y     = sel ? bus4.cfgY : bus8.cfgY;
   assign o_xs    = sel ? bus4.cfgXspeed : bus8.cfgXspeed;
   assign o_ys    = sel ? bus4.cfgYspeed : bus8.cfgYspeed;
   assign o_size  = sel ? bus4.cfgSize : bus8.cfgSize;
   assign o_act   = sel ? {4'b0, act4} : act8;
   assign o_clr   = sel ? clr4 : clr8;
   assign o_ovf   = sel ? ovf4 : ovf8;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic nxt;
      @(negedge clk);
   endtask

   task automatic level_start;
      ls = 1'b1;
      #1 check_eq("ls_ready_low", 32'(o_ready), 0);
      nxt;
      ls = 1'b0;
      check_eq("lvl_load", 32'(o_load), 1);
      check_eq("lvl_slot", 32'(o_slot), 0);
      check_eq("lvl_x", 32'(o_x), 100);
      check_eq("lvl_y", 32'(o_y), 100);
      check_eq("lvl_xs", 32'(o_xs), 32'h0040);
      check_eq("lvl_ys", 32'(o_ys), 0);
      check_eq("lvl_size", 32'(o_size), 3);
      nxt;
      check_eq("lvl_active", 32'(o_act), 1);
      check_eq("lvl_ovf", 32'(o_ovf), 0);
      check_eq("lvl_ready", 32'(o_ready), 1);
      check_eq("lvl_load_off", 32'(o_load), 0);
      $display("level_start pool=%0d active=0x%0h", sel ? 4 : 8, o_act);
   endtask

   // cs: child size, or -1 for a size-0 pop. rslot: right child slot, or -1 when dropped.
   task automatic hit(input int slot, input int x, input int y, input int cs, input int rslot,
                      input int act_after, input bit clr, input bit ls_at_l);
      check_eq("hit_ready", 32'(o_ready), 1);
      hv = 1'b1; hs = 3'(slot); hx = 11'(x); hy = 11'(y);
      nxt;
      hv = 1'b0;
      if (cs < 0) begin
         check_eq("pop_load", 32'(o_load), 0);
         check_eq("pop_active", 32'(o_act), 32'(act_after));
         check_eq("pop_cleared", 32'(o_clr), 32'(clr));
         nxt;
         check_eq("pop_cleared_off", 32'(o_clr), 0);
         check_eq("pop_ready", 32'(o_ready), 1);
      end else begin
         check_eq("l_load", 32'(o_load), 1);
         check_eq("l_slot", 32'(o_slot), 32'(slot));
         check_eq("l_x", 32'(o_x), 32'(x));
         check_eq("l_y", 32'(o_y), 32'(y));
         check_eq("l_xs", 32'(o_xs), 32'hFFC0);
         check_eq("l_ys", 32'(o_ys), 32'hFF00);
         check_eq("l_size", 32'(o_size), 32'(cs));
         if (ls_at_l) ls = 1'b1;
         nxt;
         ls = 1'b0;
         if (rslot >= 0) begin
            check_eq("r_load", 32'(o_load), 1);
            check_eq("r_slot", 32'(o_slot), 32'(rslot));
            check_eq("r_x", 32'(o_x), 32'(x));
            check_eq("r_xs", 32'(o_xs), 32'h0040);
            check_eq("r_size", 32'(o_size), 32'(cs));
         end else begin
            check_eq("r_load_drop", 32'(o_load), 0);
         end
         nxt;
         check_eq("chk_active", 32'(o_act), 32'(act_after));
         check_eq("chk_cleared", 32'(o_clr), 32'(clr));
         check_eq("chk_load", 32'(o_load), 0);
         check_eq("chk_ready", 32'(o_ready), 0);
         nxt;
         if (!ls_at_l) check_eq("split_ready", 32'(o_ready), 1);
      end
      $display("hit pool=%0d slot=%0d child_size=%0d right=%0d active=0x%0h", sel ? 4 : 8, slot, cs, rslot, o_act);
   endtask

   // 4-slot walk: fill the pool, overflow once, then pop everything.
   int t_slot [14] = '{0, 0, 1, 0, 0, 1, 0, 1, 2, 0, 2, 3, 0, 3};
   int t_cs   [14] = '{2, 1, 1, 0, -1, 0, -1, -1, 0, -1, -1, 0, -1, -1};
   int t_r    [14] = '{1, 2, 3, -1, -1, 0, -1, -1, 0, -1, -1, 0, -1, -1};
   int t_act  [14] = '{3, 7, 15, 15, 14, 15, 14, 12, 13, 12, 8, 9, 8, 0};

   initial begin
      sel = 1'b0; hv = 1'b0; hs = '0; hx = '0; hy = '0; ls = 1'b0;
      resetN = 1'b0;
      repeat (2) nxt;
      check_eq("rst_ready", 32'(o_ready), 1);
      check_eq("rst_load", 32'(o_load), 0);
      check_eq("rst_x", 32'(o_x), 0);
      check_eq("rst_size", 32'(o_size), 0);
      check_eq("rst_active", 32'(o_act), 0);
      check_eq("rst_cleared", 32'(o_clr), 0);
      check_eq("rst_ovf", 32'(o_ovf), 0);
      resetN = 1'b1;
      nxt;

      level_start();
      hit(0, 200, 300, 2, 1, 8'h03, 1'b0, 1'b0);

      hv = 1'b1; hs = 3'd5; hx = 11'd9; hy = 11'd9;
      nxt;
      hv = 1'b0;
      check_eq("dead_load", 32'(o_load), 0);
      check_eq("dead_ready", 32'(o_ready), 1);
      check_eq("dead_active", 32'(o_act), 32'h03);
      $display("hit pool=8 slot=5 inactive active=0x%0h", o_act);

      hit(1, 50, 60, 1, 2, 8'h07, 1'b0, 1'b1);
      check_eq("pend_ready", 32'(o_ready), 0);
      nxt;
      check_eq("pend_lvl_load", 32'(o_load), 1);
      check_eq("pend_lvl_slot", 32'(o_slot), 0);
      check_eq("pend_lvl_size", 32'(o_size), 3);
      nxt;
      check_eq("pend_active", 32'(o_act), 32'h01);
      check_eq("pend_ready_back", 32'(o_ready), 1);
      $display("pending level start active=0x%0h", o_act);

      hv = 1'b1; hs = 3'd0; hx = 11'd7; hy = 11'd9;
      nxt;
      hv = 1'b0;
      check_eq("rstr_l_load", 32'(o_load), 1);
      nxt;
      check_eq("rstr_r_slot", 32'(o_slot), 1);
      resetN = 1'b0;
      #1;
      check_eq("rstr_load", 32'(o_load), 0);
      check_eq("rstr_active", 32'(o_act), 0);
      check_eq("rstr_x", 32'(o_x), 0);
      check_eq("rstr_size", 32'(o_size), 0);
      nxt;
      resetN = 1'b1;
      nxt;
      check_eq("rstr_ready", 32'(o_ready), 1);
      check_eq("rstr_load_after", 32'(o_load), 0);
      $display("reset during split active=0x%0h", o_act);

      sel = 1'b1;
      #1;
      level_start();
      for (int i = 0; i < 14; i++) begin
         hit(t_slot[i], 10 * i + 5, 20 * i + 3, t_cs[i], t_r[i], t_act[i], i == 13, 1'b0);
         if (i == 3) check_eq("ovf_set", 32'(o_ovf), 1);
      end
      check_eq("ovf_sticky", 32'(o_ovf), 1);
      level_start();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
